// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths, FSM encoding and FIFO entry layout for the write-back sequencer
package reg_wb_pkg;
  localparam int REG_W = 32;
  localparam int SEL_W = 5;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wb_state_t;
  typedef struct packed {
    logic [0:SEL_W-1] sel;
    logic [0:REG_W-1] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of write-back entries with a per-slot valid/sel view
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [0:SEL_W-1]           din_sel,
  input  logic [0:REG_W-1]           din_data,
  output logic [0:SEL_W-1]           dout_sel,
  output logic [0:REG_W-1]           dout_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH*SEL_W-1:0]     ent_sel
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = '{sel: din_sel, data: din_data};
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  // A slot is live when its distance from the read pointer is below the fill count
  always_comb begin
    ent_valid = '0;
    ent_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = {1'b0, AW'(i) - rd_q} < count_q;
      ent_sel[i*SEL_W +: SEL_W] = mem_q[i].sel;
    end
  end
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout_sel = mem_q[rd_q].sel;
  assign dout_data = mem_q[rd_q].data;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/load results into a FIFO and replays them as glitch-free WriteC pulses
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [0:4]    alu_sel,
  input  logic [0:31]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [0:4]    mem_sel,
  input  logic [0:31]   mem_data,
  output logic [0:31]   busC,
  output logic [0:4]    busCsel,
  output logic          WriteC,
  output logic [0:31]   pend_mask,
  output logic          wb_idle
);
  localparam int AW = $clog2(DEPTH);
  wb_state_t state_q, state_d;
  logic [0:REG_W-1] busc_q, busc_d, in_data, head_data;
  logic [0:SEL_W-1] buscsel_q, buscsel_d, in_sel, head_sel;
  logic writec_q, writec_d;
  logic full, empty, push, pop, mem_xfer, alu_xfer;
  logic [AW:0] count;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH*SEL_W-1:0] ent_sel;
  logic [0:(1<<SEL_W)-1] mask;
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_xfer = mem_valid && mem_ready;
  assign alu_xfer = alu_valid && alu_ready;
  assign in_sel = mem_xfer ? mem_sel : alu_sel;
  assign in_data = mem_xfer ? mem_data : alu_data;
  // Register 0 writes complete the handshake but are dropped here
  assign push = (mem_xfer || alu_xfer) && in_sel != '0;
  assign pop = !empty && (state_q == IDLE || state_q == HOLD);
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din_sel   (in_sel),
    .din_data  (in_data),
    .dout_sel  (head_sel),
    .dout_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_sel   (ent_sel)
  );
  always_comb begin
    state_d = state_q == SETUP ? STROBE : state_q == STROBE ? HOLD : pop ? SETUP : IDLE;
    busc_d = pop ? head_data : busc_q;
    buscsel_d = pop ? head_sel : buscsel_q;
    writec_d = state_d == STROBE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      busc_q <= '0;
      buscsel_q <= '0;
      writec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busc_q <= busc_d;
      buscsel_q <= buscsel_d;
      writec_q <= writec_d;
    end
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i]) mask[ent_sel[i*SEL_W +: SEL_W]] = 1'b1;
    if (state_q != IDLE) mask[buscsel_q] = 1'b1;
    mask[0] = 1'b0;
  end
  assign pend_mask = mask;
  assign busC = busc_q;
  assign busCsel = buscsel_q;
  assign WriteC = writec_q;
  assign wb_idle = count == '0 && state_q == IDLE;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios for the write-back sequencer with a WriteC pulse log
module tb_reg_writeback;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic alu_ready, mem_ready;
  logic [0:4] alu_sel = '0, mem_sel = '0;
  logic [0:31] alu_data = '0, mem_data = '0;
  logic [0:31] busC, pend_mask;
  logic [0:4] busCsel;
  logic WriteC, wb_idle;
  int vectors = 0, miscompares = 0, cyc = 0, hi_cnt = 0;
  logic prev_w = 1'b0;
  int p_sel[$];
  logic [31:0] p_data[$];
  int p_cyc[$];

  reg_writeback #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_sel   (alu_sel),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_sel   (mem_sel),
    .mem_data  (mem_data),
    .busC      (busC),
    .busCsel   (busCsel),
    .WriteC    (WriteC),
    .pend_mask (pend_mask),
    .wb_idle   (wb_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (WriteC && !prev_w) begin
      p_sel.push_back(int'(busCsel));
      p_data.push_back(busC);
      p_cyc.push_back(cyc);
    end
    if (WriteC) hi_cnt++;
    prev_w = WriteC;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    p_sel.delete();
    p_data.delete();
    p_cyc.delete();
    hi_cnt = 0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!wb_idle && n < bound) begin
      tick;
      n++;
    end
    vectors++;
    if (!wb_idle) begin
      miscompares++;
      $display("FAIL wait_idle: wb_idle=%b after %0d cycles, want 1", wb_idle, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick;
    vectors += 3;
    if ({WriteC, wb_idle, alu_ready, mem_ready} !== 4'b0111) begin
      miscompares++;
      $display("FAIL reset_ctrl: {WriteC,idle,alu_rdy,mem_rdy}=%b want 0111", {WriteC, wb_idle, alu_ready, mem_ready});
    end
    if (pend_mask !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pend: got %h want 00000000", pend_mask);
    end
    if ({busCsel, busC} !== 37'h0) begin
      miscompares++;
      $display("FAIL reset_bus: sel=%0d data=%h want 0/0", busCsel, busC);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [0:31] em;
    clear_log;
    alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      em = '0;
      if (t <= 3) em[5] = 1'b1;
      vectors += 4;
      if (WriteC !== (t == 2)) begin
        miscompares++;
        $display("FAIL single_writec N+%0d: got %b want %b", t, WriteC, t == 2);
      end
      if ({busCsel, busC} !== (t >= 1 ? {5'd5, 32'hDEADBEEF} : 37'h0)) begin
        miscompares++;
        $display("FAIL single_bus N+%0d: sel=%0d data=%h", t, busCsel, busC);
      end
      if (pend_mask !== em) begin
        miscompares++;
        $display("FAIL single_pend N+%0d: got %h want %h", t, pend_mask, em);
      end
      if (wb_idle !== (t == 4)) begin
        miscompares++;
        $display("FAIL single_idle N+%0d: got %b want %b", t, wb_idle, t == 4);
      end
      if (t < 4) tick;
    end
    vectors++;
    if (p_sel.size() != 1 || hi_cnt != 1) begin
      miscompares++;
      $display("FAIL single_pulses: pulses=%0d high_cycles=%0d want 1/1", p_sel.size(), hi_cnt);
    end
  endtask

  task automatic test_priority;
    clear_log;
    mem_valid = 1'b1; mem_sel = 5'd3; mem_data = 32'h3333_0003;
    alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 32'h7777_0007;
    #1;
    vectors++;
    if ({mem_ready, alu_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL prio_ready: {mem,alu}=%b want 10", {mem_ready, alu_ready});
    end
    tick;
    mem_valid = 1'b0;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_alu_next: got %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    wait_idle(20);
    vectors++;
    if (p_sel.size() != 2 || hi_cnt != 2) begin
      miscompares++;
      $display("FAIL prio_count: pulses=%0d high_cycles=%0d want 2/2", p_sel.size(), hi_cnt);
    end else begin
      vectors += 3;
      if (p_sel[0] != 3 || p_data[0] !== 32'h3333_0003) begin
        miscompares++;
        $display("FAIL prio_first: sel=%0d data=%h want 3/33330003", p_sel[0], p_data[0]);
      end
      if (p_sel[1] != 7 || p_data[1] !== 32'h7777_0007) begin
        miscompares++;
        $display("FAIL prio_second: sel=%0d data=%h want 7/77770007", p_sel[1], p_data[1]);
      end
      if (p_cyc[1] - p_cyc[0] != 3) begin
        miscompares++;
        $display("FAIL prio_spacing: got %0d want 3", p_cyc[1] - p_cyc[0]);
      end
    end
  endtask

  task automatic test_fill;
    int stalls[8];
    int exp_stalls[8] = '{0, 0, 0, 0, 0, 0, 2, 2};
    clear_log;
    for (int k = 0; k < 8; k++) begin
      stalls[k] = 0;
      alu_valid = 1'b1; alu_sel = 5'(k + 1); alu_data = 32'hA000_0000 + 32'(k);
      #1;
      while (!alu_ready && stalls[k] < 20) begin
        tick;
        stalls[k]++;
      end
      tick;
    end
    alu_valid = 1'b0;
    wait_idle(60);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (stalls[k] != exp_stalls[k]) begin
        miscompares++;
        $display("FAIL fill_stall[%0d]: got %0d cycles want %0d", k, stalls[k], exp_stalls[k]);
      end
    end
    vectors++;
    if (p_sel.size() != 8 || hi_cnt != 8) begin
      miscompares++;
      $display("FAIL fill_count: pulses=%0d high_cycles=%0d want 8/8", p_sel.size(), hi_cnt);
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (p_sel[k] != k + 1 || p_data[k] !== 32'hA000_0000 + 32'(k)) begin
          miscompares++;
          $display("FAIL fill_order[%0d]: sel=%0d data=%h want %0d/%h", k, p_sel[k], p_data[k], k + 1, 32'hA000_0000 + 32'(k));
        end
        if (k > 0) begin
          vectors++;
          if (p_cyc[k] - p_cyc[k-1] != 3) begin
            miscompares++;
            $display("FAIL fill_spacing[%0d]: got %0d want 3", k, p_cyc[k] - p_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_zero;
    clear_log;
    alu_valid = 1'b1; alu_sel = 5'd0; alu_data = 32'h12345678;
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      vectors++;
      if ({pend_mask, wb_idle, WriteC} !== {32'h0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL zero_quiet t=%0d: pend=%h idle=%b writec=%b want 0/1/0", t, pend_mask, wb_idle, WriteC);
      end
      tick;
    end
    vectors += 2;
    if (hi_cnt != 0) begin
      miscompares++;
      $display("FAIL zero_pulse: high_cycles=%0d want 0", hi_cnt);
    end
    if ({busCsel, busC} !== {5'd8, 32'hA000_0007}) begin
      miscompares++;
      $display("FAIL zero_bus_hold: sel=%0d data=%h want 8/a0000007", busCsel, busC);
    end
  endtask

  task automatic test_reset_strobe;
    clear_log;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_sel = 5'(10 + k); alu_data = 32'hC000_0000 + 32'(k);
      tick;
    end
    alu_valid = 1'b0;
    vectors++;
    if (WriteC !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_strobe_pre: writec=%b want 1", WriteC);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({WriteC, pend_mask, wb_idle} !== {1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_strobe_async: writec=%b pend=%h idle=%b want 0/0/1", WriteC, pend_mask, wb_idle);
    end
    repeat (2) tick;
    reset = 1'b1;
    repeat (10) tick;
    vectors++;
    if (hi_cnt != 0 || p_sel.size() != 0 || wb_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_strobe_after: high_cycles=%0d pulses=%0d idle=%b want 0/0/1", hi_cnt, p_sel.size(), wb_idle);
    end
  endtask

  task automatic test_same_reg;
    clear_log;
    alu_valid = 1'b1; alu_sel = 5'd9; alu_data = 32'h1;
    tick;
    alu_data = 32'h2;
    for (int t = 0; t < 7; t++) begin
      vectors++;
      if (pend_mask[9] !== 1'b1) begin
        miscompares++;
        $display("FAIL same_pend9 E%0d: got %b want 1", t, pend_mask[9]);
      end
      tick;
      alu_valid = 1'b0;
    end
    vectors++;
    if ({pend_mask, wb_idle} !== {32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL same_clear: pend=%h idle=%b want 0/1", pend_mask, wb_idle);
    end
    vectors++;
    if (p_sel.size() != 2) begin
      miscompares++;
      $display("FAIL same_count: pulses=%0d want 2", p_sel.size());
    end else begin
      vectors++;
      if (p_sel[0] != 9 || p_sel[1] != 9 || p_data[0] !== 32'h1 || p_data[1] !== 32'h2) begin
        miscompares++;
        $display("FAIL same_order: %0d/%h then %0d/%h want 9/1 then 9/2", p_sel[0], p_data[0], p_sel[1], p_data[1]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_fill;
    test_zero;
    test_reset_strobe;
    test_same_reg;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back sequencer feeding the register bank's C port. Accepts destination/data results from the ALU and the load unit over valid/ready handshakes, buffers them in a small FIFO, and replays each one onto busC/busCsel with a clean, glitch-free WriteC pulse. The bank captures on the rising edge of WriteC, so busC and busCsel must be stable before that edge. Also exports a pending-write mask for the hazard logic in the decode stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_sel  in  [0:4]  ALU destination register.
- alu_data  in  [0:31]  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load result accepted this cycle.
- mem_sel  in  [0:4]  load destination register.
- mem_data  in  [0:31]  load data.
- busC  out  [0:31]  write data to the register bank.
- busCsel  out  [0:4]  write address to the register bank.
- WriteC  out  1  write strobe; the bank captures on its rising edge.
- pend_mask  out  [0:31]  bit i = 1 while a write to register i is queued or in flight; bit 0 is always 0.
- wb_idle  out  1  FIFO empty and FSM in IDLE.

## Operation
- Input arbitration: fixed priority, mem over alu. At most one enqueue per cycle.
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
  - A transfer occurs when valid && ready are both high at the clock edge.
- Writes to register 0 are accepted and discarded. They never enter the FIFO and never assert WriteC.
- FIFO: DEPTH entries of {sel[0:4], data[0:31]}, wrapping read/write pointers, count register.
  - full = (count == DEPTH); empty = (count == 0).
  - Simultaneous enqueue and dequeue when full is allowed: the dequeue happens in the same edge, but ready is still computed from full, so the enqueue is refused that cycle.
- FSM, encoding in the package:
  - IDLE: if the FIFO is not empty, pop the head into the output registers (busC, busCsel) and go to SETUP.
  - SETUP: WriteC=0, bus stable. Go to STROBE.
  - STROBE: WriteC=1. Go to HOLD.
  - HOLD: WriteC=0, bus still held. If the FIFO is not empty, pop the next entry and go to SETUP; otherwise go to IDLE.
- WriteC is driven directly from a flop (state==STROBE registered), never decoded combinationally.
- busC and busCsel change only on a pop (the IDLE→SETUP or HOLD→SETUP transition). In IDLE they keep their last value.
- pend_mask is the OR of the one-hot decode of every valid FIFO entry's sel, plus busCsel while the FSM is in SETUP, STROBE or HOLD. It is combinational from registered state. Bit 0 is forced to 0.

## Timing
- Reset (asynchronous, immediate): FIFO emptied, state = IDLE, busC = 0, busCsel = 0, WriteC = 0, pend_mask = 0, wb_idle = 1.
  - alu_ready and mem_ready are 1 after reset because the FIFO is empty.
  - Reset asserted during STROBE drops WriteC immediately; all queued and in-flight entries are lost.
- Latency: an entry accepted at edge N into an empty FIFO with the FSM in IDLE:
  - is popped at edge N+1 (SETUP);
  - WriteC rises at edge N+2;
  - WriteC falls at edge N+3;
  - the FSM returns to IDLE at edge N+4 if nothing else is queued.
- Throughput: one register write per 3 cycles while the FIFO is not empty.
- Data and address setup to the WriteC rising edge is one full clock. Hold after the falling edge is one full clock.
- Two queued writes to the same register are both replayed in order; the last one wins.
- pend_mask stays set for a register until the HOLD cycle of its last queued write has ended.

## Structure
- Package reg_wb_pkg:
  - state encoding (IDLE, SETUP, STROBE, HOLD);
  - REG_W = 32, SEL_W = 5;
  - the entry field layout.
- Sub-module wb_fifo: parameterised DEPTH synchronous FIFO with push/pop, full/empty/count, and a flat valid+sel view of every entry for pend_mask.
- The top level holds the arbiter, FSM, output registers and mask OR-tree.

## Test plan
- Reset, then a single alu write sel=5, data=0xDEADBEEF. Required:
  - WriteC high exactly one cycle, at edge N+2;
  - busCsel=5 and busC=0xDEADBEEF stable from N+1 through N+3;
  - pend_mask bit 5 set from N+1 until the end of HOLD.
- mem_valid and alu_valid both high, sels 3 and 7. Required:
  - mem accepted first, alu_ready=0 that cycle;
  - alu accepted the next cycle;
  - two WriteC pulses, for sel 3 then sel 7, 3 cycles apart.
- Push DEPTH+1 writes back-to-back while the FSM is busy. Required:
  - ready deasserts when count==DEPTH;
  - no entry is lost or duplicated;
  - pulses come out in FIFO order after the pointer wrap.
- alu write to sel=0 with data 0x12345678. Required:
  - alu_ready=1;
  - no WriteC pulse;
  - pend_mask stays 0;
  - wb_idle stays 1.
- Assert reset during STROBE with 2 entries queued. Required:
  - WriteC=0 immediately;
  - pend_mask=0;
  - no further pulses after reset is released.
- Two writes to sel=9 (0x1, then 0x2). Required:
  - two pulses in order;
  - pend_mask bit 9 stays 1 continuously until the second HOLD completes.
